// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Holds busy for a fixed cycle count, then commits the result and pulses done.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] dataW,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_signed;
  logic               w_is_div;
  logic               w_neg_a;
  logic               w_neg_b;
  logic               w_div_zero;
  logic               w_commit;
  logic               w_commit_write;
  logic [CW-1:0]      w_load_count;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH-1:0]   w_mag_q;
  logic [WIDTH-1:0]   w_mag_r;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Result datapath evaluated from captured operands and current HI/LO.
  always_comb begin
    w_signed   = ~r_op[0];
    w_is_div   = (r_op[2:1] == 2'b01);
    w_neg_a    = w_signed & r_a[WIDTH-1];
    w_neg_b    = w_signed & r_b[WIDTH-1];
    w_div_zero = (r_b == {WIDTH{1'b0}});

    w_ext_a = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    w_ext_b = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
    w_prod  = w_ext_a * w_ext_b;
    w_acc   = r_op[1] ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);

    // Sign-magnitude divide; the most-negative dividend's magnitude is exact as unsigned.
    w_mag_a = w_neg_a ? (-r_a) : r_a;
    w_mag_b = w_neg_b ? (-r_b) : r_b;
    if (w_div_zero) begin
      w_mag_q = {WIDTH{1'b0}};
      w_mag_r = {WIDTH{1'b0}};
    end else begin
      w_mag_q = w_mag_a / w_mag_b;
      w_mag_r = w_mag_a % w_mag_b;
    end
    w_quot = (w_neg_a ^ w_neg_b) ? (-w_mag_q) : w_mag_q;
    w_rem  = w_neg_a ? (-w_mag_r) : w_mag_r;

    case (r_op)
      3'b000, 3'b001: {w_res_hi, w_res_lo} = w_prod;
      3'b010, 3'b011: {w_res_hi, w_res_lo} = {w_rem, w_quot};
      3'b100, 3'b101,
      3'b110, 3'b111: {w_res_hi, w_res_lo} = w_acc;
      default:        {w_res_hi, w_res_lo} = {r_hi, r_lo};
    endcase

    w_commit       = (r_state == ST_RUN) && (r_count == CW'(1'b1));
    w_commit_write = ~(w_is_div & w_div_zero);
    w_load_count   = (op[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
  end

  // Control FSM, busy down-counter, operand capture and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= {CW{1'b0}};
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_op    <= 3'b000;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= inA;
            r_b     <= inB;
            r_op    <= op;
            r_count <= w_load_count;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_commit) begin
            r_state <= ST_IDLE;
            r_count <= {CW{1'b0}};
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - CW'(1'b1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_count <= {CW{1'b0}};
        end
      endcase
    end
  end

  // HI/LO: commit at end of run (skipped on divide by zero), else direct writes when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (w_commit) begin
      if (w_commit_write) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end else if ((r_state == ST_IDLE) && !start) begin
      if (mthi) r_hi <= dataW;
      if (mtlo) r_lo <= dataW;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized ops
// compared against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inA, inB, dataW;
  logic        start, mthi, mtlo;
  logic [2:0]  op;
  logic        busy, done;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .inA(inA), .inB(inB), .start(start), .op(op),
    .mthi(mthi), .mtlo(mtlo), .dataW(dataW), .busy(busy), .done(done),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the architectural HI/LO should become after one op.
  function automatic void model_apply(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod, acc;
    longint q, r;
    if (o[0] == 1'b0) prod = 64'(longint'($signed(a)) * longint'($signed(b)));
    else              prod = {32'd0, a} * {32'd0, b};
    acc = {m_hi, m_lo};
    if (o[2:1] == 2'b01) begin
      if (b != 32'd0) begin
        if (o[0] == 1'b0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
    end else if (o[2] == 1'b0) begin
      {m_hi, m_lo} = prod;
    end else if (o[1] == 1'b0) begin
      {m_hi, m_lo} = acc + prod;
    end else begin
      {m_hi, m_lo} = acc - prod;
    end
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic poke_busy);
    int n;
    int exp_n;
    exp_n = (o[2:1] == 2'b01) ? 10 : 5;
    start = 1'b1; op = o; inA = a; inB = b;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    inA = $urandom; inB = $urandom; op = 3'($urandom_range(0, 7));
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_low_in_run", 64'(done), 64'd0);
    if (poke_busy) begin
      start = 1'b1; mthi = 1'b1; mtlo = 1'b1; dataW = $urandom;
    end
    n = 1;
    @(negedge clk);
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    model_apply(o, a, b);
    check("busy_cycles", 64'(n), 64'(exp_n));
    check("done_pulse", 64'(done), 64'd1);
    check("hi_result", 64'(HI), 64'(m_hi));
    check("lo_result", 64'(LO), 64'(m_lo));
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    mthi = h; mtlo = l; dataW = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
    check("mt_hi", 64'(HI), 64'(m_hi));
    check("mt_lo", 64'(LO), 64'(m_lo));
  endtask

  initial begin
    int dones;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 3'b000; inA = 32'd0; inB = 32'd0; dataW = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(HI), 64'd0);
    check("reset_lo", 64'(LO), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run_op(3'b000, -32'sd10, 32'd23, 1'b0);
    check("mult_hi_const", 64'(HI), 64'h0000_0000_FFFF_FFFF);
    check("mult_lo_const", 64'(LO), 64'h0000_0000_FFFF_FF1A);
    @(negedge clk);
    check("done_single_pulse", 64'(done), 64'd0);

    run_op(3'b001, -32'sd10, 32'd23, 1'b0);
    check("multu_hi_const", 64'(HI), 64'h16);
    check("multu_lo_const", 64'(LO), 64'hFFFF_FF1A);
    run_op(3'b000, -32'sd10, 32'd23, 1'b0);
    // madd launched in the done cycle sees the just-committed -230.
    run_op(3'b100, 32'd3, 32'd4, 1'b0);
    check("madd_hi_const", 64'(HI), 64'hFFFF_FFFF);
    check("madd_lo_const", 64'(LO), 64'hFFFF_FF26);
    run_op(3'b110, 32'd7, -32'sd9, 1'b0);
    run_op(3'b111, 32'hFFFF_FFFF, 32'h2, 1'b0);

    run_op(3'b010, -32'sd32, -32'sd5, 1'b0);
    check("div_lo_const", 64'(LO), 64'h6);
    check("div_hi_const", 64'(HI), 64'hFFFF_FFFE);
    run_op(3'b011, -32'sd32, -32'sd5, 1'b0);
    check("divu_lo_const", 64'(LO), 64'h0);
    check("divu_hi_const", 64'(HI), 64'hFFFF_FFE0);

    mt(1'b1, 1'b1, 32'h0);
    mt(1'b1, 1'b0, 32'h1234_5678);
    mt(1'b0, 1'b1, 32'h9ABC_DEF0);
    run_op(3'b010, 32'd77, 32'd0, 1'b0);
    check("div0_hi_const", 64'(HI), 64'h1234_5678);
    check("div0_lo_const", 64'(LO), 64'h9ABC_DEF0);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("divmin_lo_const", 64'(LO), 64'h8000_0000);
    check("divmin_hi_const", 64'(HI), 64'h0);

    mt(1'b1, 1'b0, 32'hABCD_EF00);
    mt(1'b0, 1'b1, 32'h11);
    check("mthi_const", 64'(HI), 64'hABCD_EF00);
    check("mtlo_const", 64'(LO), 64'h11);
    // Writes while busy and writes alongside start are both dropped.
    run_op(3'b011, 32'd1000, 32'd7, 1'b1);
    mthi = 1'b1; mtlo = 1'b1; dataW = 32'hDEAD_BEEF;
    run_op(3'b001, 32'd5, 32'd6, 1'b0);

    // Reset mid-divide, between clock edges.
    run_op(3'b000, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    start = 1'b1; op = 3'b010; inA = 32'd100; inB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(HI), 64'd0);
    check("async_rst_lo", 64'(LO), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (14) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    check("no_commit_after_rst", 64'(dones), 64'd0);
    check("rst_hold_hi", 64'(HI), 64'd0);
    check("rst_hold_lo", 64'(LO), 64'd0);

    // Start presented on the first edge after reset release.
    start = 1'b1; op = 3'b001; inA = 32'd9;
    @(negedge clk);
    start = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(3'b001, 32'd12, 32'd13, 1'b0);

    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
